// File: rtl/t05_find_least_pair.sv
// rtl/t05_find_least_pair.sv - scans leaf+node frequency table for the two smallest non-zero entries
module t05_find_least_pair #(
  parameter int VAL_W  = 64,
  parameter int LEAF_N = 256,
  parameter int NODE_N = 128,
  parameter int RD_LAT = 1,
  localparam int IDX_W = $clog2(LEAF_N + NODE_N),
  localparam int CH_W  = $clog2(LEAF_N),
  localparam int NC_W  = $clog2(NODE_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NC_W-1:0]  node_cnt,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [VAL_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] least1,
  output logic [IDX_W-1:0] least2,
  output logic             least1_node,
  output logic             least2_node,
  output logic [CH_W-1:0]  char1,
  output logic [CH_W-1:0]  char2,
  output logic [VAL_W-1:0] val1,
  output logic [VAL_W-1:0] val2,
  output logic [VAL_W:0]   sum,
  output logic [1:0]       found
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_FIN} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]             e_last;
  logic [RD_LAT-1:0]            tag_v;
  logic [RD_LAT-1:0][IDX_W-1:0] tag_a;
  logic [RD_LAT-1:0]            early_v;
  logic                         drain_done;
  logic [NC_W-1:0]              nodes_eff;

  logic             f1, f2, nf1, nf2;
  logic [IDX_W-1:0] a1, a2, na1, na2;
  logic [VAL_W-1:0] v1, v2, nv1, nv2;
  logic             beat;
  logic [IDX_W-1:0] beat_a;

  always_comb begin
    nodes_eff = (node_cnt > NC_W'(NODE_N)) ? NC_W'(NODE_N) : node_cnt;
    early_v = tag_v;
    early_v[RD_LAT-1] = 1'b0;
    drain_done = ~|early_v;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (rd_addr == e_last) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FIN);
  end

  // Slot emptiness lives in f1/f2 so an all-ones value is ordinary data.
  always_comb begin
    beat   = tag_v[RD_LAT-1] && (rd_data != '0);
    beat_a = tag_a[RD_LAT-1];
    nf1 = f1; na1 = a1; nv1 = v1;
    nf2 = f2; na2 = a2; nv2 = v2;
    if (beat) begin
      if (!f1 || rd_data < v1) begin
        nf2 = f1;   na2 = a1;     nv2 = v1;
        nf1 = 1'b1; na1 = beat_a; nv1 = rd_data;
      end else if (!f2 || rd_data < v2) begin
        nf2 = 1'b1; na2 = beat_a; nv2 = rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      e_last      <= '0;
      tag_v       <= '0;
      tag_a       <= '0;
      f1          <= 1'b0;
      f2          <= 1'b0;
      a1          <= '1;
      a2          <= '1;
      v1          <= '0;
      v2          <= '0;
      least1      <= '1;
      least2      <= '1;
      least1_node <= 1'b0;
      least2_node <= 1'b0;
      char1       <= '0;
      char2       <= '0;
      val1        <= '0;
      val2        <= '0;
      sum         <= '0;
      found       <= '0;
    end else begin
      tag_v[0] <= rd_en;
      tag_a[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end
      f1 <= nf1; a1 <= na1; v1 <= nv1;
      f2 <= nf2; a2 <= na2; v2 <= nv2;
      case (state_q)
        S_IDLE: if (start) begin
          rd_en   <= 1'b1;
          rd_addr <= '0;
          e_last  <= IDX_W'(LEAF_N) + IDX_W'(nodes_eff) - IDX_W'(1);
          f1 <= 1'b0; a1 <= '1; v1 <= '0;
          f2 <= 1'b0; a2 <= '1; v2 <= '0;
        end
        S_SCAN: begin
          if (rd_addr == e_last) rd_en <= 1'b0;
          else                   rd_addr <= rd_addr + IDX_W'(1);
        end
        // Results are taken from the post-compare values so the final beat is included.
        S_DRAIN: if (drain_done) begin
          least1      <= na1;
          least2      <= na2;
          least1_node <= nf1 && (na1 >= IDX_W'(LEAF_N));
          least2_node <= nf2 && (na2 >= IDX_W'(LEAF_N));
          char1       <= (nf1 && na1 < IDX_W'(LEAF_N)) ? na1[CH_W-1:0] : '0;
          char2       <= (nf2 && na2 < IDX_W'(LEAF_N)) ? na2[CH_W-1:0] : '0;
          val1        <= nv1;
          val2        <= nv2;
          sum         <= {1'b0, nv1} + {1'b0, nv2};
          found       <= {1'b0, nf1} + {1'b0, nf2};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_find_least_pair.sv
// tb/tb_t05_find_least_pair.sv - directed bench, three instances at RD_LAT 1, 2 and 3
module tb_t05_find_least_pair;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] node_cnt = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [384];

  logic        rd_en   [3];
  logic [8:0]  rd_addr [3];
  logic        busy    [3];
  logic        done    [3];
  logic [8:0]  least1  [3];
  logic [8:0]  least2  [3];
  logic        l1_node [3];
  logic        l2_node [3];
  logic [7:0]  char1   [3];
  logic [7:0]  char2   [3];
  logic [63:0] val1    [3];
  logic [63:0] val2    [3];
  logic [64:0] sum     [3];
  logic [1:0]  found   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [63:0] p0, p1, p2, rdata;
    always @(posedge clk) begin
      p0 <= mem[rd_addr[g]];
      p1 <= p0;
      p2 <= p1;
    end
    assign rdata = (g == 0) ? p0 : (g == 1) ? p1 : p2;

    t05_find_least_pair #(.RD_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .start(start), .node_cnt(node_cnt),
      .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rdata),
      .busy(busy[g]), .done(done[g]),
      .least1(least1[g]), .least2(least2[g]),
      .least1_node(l1_node[g]), .least2_node(l2_node[g]),
      .char1(char1[g]), .char2(char2[g]),
      .val1(val1[g]), .val2(val2[g]), .sum(sum[g]), .found(found[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int k_start;
  int done_at [3];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 384; i++) mem[i] = '0;
  endtask

  task automatic run_scan(input logic [7:0] nc);
    bit seen [3];
    @(negedge clk);
    node_cnt = nc;
    start = 1'b1;
    k_start = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin seen[g] = 1'b0; done_at[g] = -1; end
    for (int i = 0; i < 1000; i++) begin
      for (int g = 0; g < 3; g++)
        if (done[g] && !seen[g]) begin seen[g] = 1'b1; done_at[g] = cyc; end
      if (seen[0] && seen[1] && seen[2]) break;
      @(negedge clk);
    end
    chk("done_seen", {seen[0], seen[1], seen[2]}, 3'b111);
  endtask

  task automatic check_res(input string nm, input logic [8:0] e_l1, input logic [8:0] e_l2,
                           input logic [63:0] e_v1, input logic [63:0] e_v2,
                           input logic [64:0] e_sum, input logic [1:0] e_found, input int e_cnt);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_least1_lat%0d", nm, g + 1), least1[g], e_l1);
      chk($sformatf("%s_least2_lat%0d", nm, g + 1), least2[g], e_l2);
      chk($sformatf("%s_val1_lat%0d", nm, g + 1), val1[g], e_v1);
      chk($sformatf("%s_val2_lat%0d", nm, g + 1), val2[g], e_v2);
      chk($sformatf("%s_sum_lat%0d", nm, g + 1), sum[g], e_sum);
      chk($sformatf("%s_found_lat%0d", nm, g + 1), found[g], e_found);
      chk($sformatf("%s_done_lat%0d", nm, g + 1), done_at[g] - k_start, e_cnt + g + 2);
    end
  endtask

  task automatic check_reset_state(input string nm);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_rd_en_%0d", nm, g), rd_en[g], 1'b0);
      chk($sformatf("%s_rd_addr_%0d", nm, g), rd_addr[g], 9'd0);
      chk($sformatf("%s_busy_%0d", nm, g), busy[g], 1'b0);
      chk($sformatf("%s_done_%0d", nm, g), done[g], 1'b0);
      chk($sformatf("%s_least1_%0d", nm, g), least1[g], 9'h1ff);
      chk($sformatf("%s_least2_%0d", nm, g), least2[g], 9'h1ff);
      chk($sformatf("%s_node1_%0d", nm, g), l1_node[g], 1'b0);
      chk($sformatf("%s_char1_%0d", nm, g), char1[g], 8'd0);
      chk($sformatf("%s_val1_%0d", nm, g), val1[g], 64'd0);
      chk($sformatf("%s_sum_%0d", nm, g), sum[g], 65'd0);
      chk($sformatf("%s_found_%0d", nm, g), found[g], 2'd0);
    end
  endtask

  task automatic load_leaves();
    clear_mem();
    mem[65]  = 64'd5;
    mem[66]  = 64'd3;
    mem[200] = 64'd3;
    mem[260] = 64'd1;
  endtask

  initial begin
    int dcnt;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    load_leaves();
    run_scan(8'd0);
    check_res("leaves", 9'd66, 9'd200, 64'd3, 64'd3, 65'd6, 2'd2, 256);
    chk("leaves_char1", char1[0], 8'd66);
    chk("leaves_char2", char2[0], 8'd200);
    chk("leaves_node1", l1_node[0], 1'b0);

    clear_mem();
    mem[10] = 64'd9; mem[257] = 64'd2; mem[259] = 64'd7; mem[300] = 64'd1;
    run_scan(8'd4);
    check_res("node", 9'd257, 9'd259, 64'd2, 64'd7, 65'd9, 2'd2, 260);
    chk("node_l1node", l1_node[0], 1'b1);
    chk("node_char1", char1[0], 8'd0);
    chk("node_l2node", l2_node[0], 1'b1);

    clear_mem();
    mem[5] = 64'd6; mem[383] = 64'd1;
    run_scan(8'd200);
    check_res("clamp", 9'd383, 9'd5, 64'd1, 64'd6, 65'd7, 2'd2, 384);
    chk("clamp_char2", char2[0], 8'd5);
    chk("clamp_l2node", l2_node[0], 1'b0);

    clear_mem();
    mem[0] = 64'd4;
    run_scan(8'd0);
    check_res("single", 9'd0, 9'h1ff, 64'd4, 64'd0, 65'd4, 2'd1, 256);

    clear_mem();
    run_scan(8'd128);
    check_res("empty", 9'h1ff, 9'h1ff, 64'd0, 64'd0, 65'd0, 2'd0, 384);

    clear_mem();
    mem[1] = '1; mem[2] = '1;
    run_scan(8'd0);
    check_res("ovf", 9'd1, 9'd2, '1, '1, 65'h1_ffff_ffff_ffff_fffe, 2'd2, 256);

    load_leaves();
    @(negedge clk);
    node_cnt = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && !(rd_en[0] && rd_addr[0] == 9'd100); i++) @(negedge clk);
    chk("abort_addr", rd_addr[0], 9'd100);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (done[g]) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_scan(8'd0);
    check_res("restart", 9'd66, 9'd200, 64'd3, 64'd3, 65'd6, 2'd2, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
